// File: rtl/midi_event_tx.sv
// rtl/midi_event_tx.sv - debounced note state to MIDI Note On/Off serial transmitter
module midi_event_tx #(
    parameter int F_CLK       = 12_000_000,
    parameter int BAUD        = 31250,
    parameter int CHANNEL     = 0,
    parameter int VELOCITY    = 100,
    parameter int HOLD_CYCLES = 1200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] midi,
    input  logic       note_on,
    output logic       tx,
    output logic       busy
);
    localparam int DIV    = F_CLK / BAUD;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [3:0]        CHAN     = 4'(CHANNEL);
    localparam logic [6:0]        VEL      = 7'(VELOCITY);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]        key, key_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic              filt_on;
    logic [6:0]        filt_note;

    state_t            state, state_n;
    logic [1:0]        byte_idx, byte_n;
    logic [2:0]        bit_idx, bit_n;
    logic [DIV_W-1:0]  div_cnt, div_n;
    logic [2:0][7:0]   msg, msg_n;
    logic              snd_on, snd_on_n;
    logic [6:0]        snd_note, snd_note_n;
    logic              tx_n, busy_n, bit_end;

    // The note number is masked while note_on is low so it cannot restart the hold count.
    assign key = note_on ? {1'b1, midi} : 8'h00;

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_q     <= 8'h00;
            hold_cnt  <= '0;
            filt_on   <= 1'b0;
            filt_note <= 7'd0;
        end else begin
            key_q <= key;
            if (key != key_q)
                hold_cnt <= '0;
            else if (hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + HOLD_W'(1);
            if (hold_cnt == HOLD_MAX)
                {filt_on, filt_note} <= key_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            byte_idx <= 2'd0;
            bit_idx  <= 3'd0;
            div_cnt  <= '0;
            msg      <= '0;
            snd_on   <= 1'b0;
            snd_note <= 7'd0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            byte_idx <= byte_n;
            bit_idx  <= bit_n;
            div_cnt  <= div_n;
            msg      <= msg_n;
            snd_on   <= snd_on_n;
            snd_note <= snd_note_n;
            tx       <= tx_n;
            busy     <= busy_n;
        end
    end

    assign bit_end = (div_cnt == DIV_LAST);

    always_comb begin
        state_n    = state;
        byte_n     = byte_idx;
        bit_n      = bit_idx;
        div_n      = div_cnt;
        msg_n      = msg;
        snd_on_n   = snd_on;
        snd_note_n = snd_note;
        case (state)
            IDLE: begin
                div_n  = '0;
                byte_n = 2'd0;
                bit_n  = 3'd0;
                if (filt_on && !snd_on) begin
                    msg_n      = {{1'b0, VEL}, {1'b0, filt_note}, {4'h9, CHAN}};
                    snd_on_n   = 1'b1;
                    snd_note_n = filt_note;
                    state_n    = START;
                end else if (snd_on && (!filt_on || filt_note != snd_note)) begin
                    // A note change goes out as Off first; the next IDLE pass sends the new On.
                    msg_n    = {8'h40, {1'b0, snd_note}, {4'h8, CHAN}};
                    snd_on_n = 1'b0;
                    state_n  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    div_n   = '0;
                    state_n = DATA;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_n = '0;
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                    else
                        bit_n = bit_idx + 3'd1;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    div_n = '0;
                    bit_n = 3'd0;
                    if (byte_idx == 2'd2) begin
                        state_n = IDLE;
                    end else begin
                        byte_n  = byte_idx + 2'd1;
                        state_n = START;
                    end
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // tx and busy are registered from the next state so they stay aligned and glitch-free.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = msg_n[byte_n][bit_n];
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
    end
endmodule
